score_engine: RTL and testbench

- Parametrised successor of the score ALU for the Pac-Man datapath.
- Accepts one game event per cycle from the game FSM (pellet, power pellet, ghost, fruit, double, power-end).
- Maintains a saturating score, a ghost combo multiplier, a session high score, and extra-life pulses at configurable score steps.
- Feeds the HUD renderer and the lives counter.

---
 rtl/score_engine.sv | 165 ++++++++++++++++
 tb/tb_score_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_engine.sv
// +----------------------------------------------------------------------------+
// | score_engine: saturating score, ghost combo, high score, extra-life pulses |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module score_engine #(
  parameter int SCORE_W    = 24,
  parameter int PELLET_PTS = 10,
  parameter int POWER_PTS  = 50,
  parameter int GHOST_BASE = 200,
  parameter int COMBO_MAX  = 3,
  parameter int LIFE_STEP  = 10000,
  parameter int MAX_BONUS  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               freeze,
  input  logic               event_valid,
  input  logic [2:0]         event_type,
  input  logic [15:0]        fruit_pts,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [SCORE_W-1:0] last_award,
  output logic [2:0]         combo,
  output logic               extra_life,
  output logic               saturated
);

  localparam logic [2:0] EV_PELLET    = 3'd0;
  localparam logic [2:0] EV_POWER     = 3'd1;
  localparam logic [2:0] EV_GHOST     = 3'd2;
  localparam logic [2:0] EV_FRUIT     = 3'd3;
  localparam logic [2:0] EV_DOUBLE    = 3'd4;
  localparam logic [2:0] EV_POWER_END = 3'd5;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] PELLET_AWD = SCORE_W'(PELLET_PTS);
  localparam logic [SCORE_W-1:0] POWER_AWD  = SCORE_W'(POWER_PTS);
  localparam logic [SCORE_W-1:0] GHOST_AWD  = SCORE_W'(GHOST_BASE);
  localparam logic [SCORE_W:0]   LIFE_INC   = (SCORE_W+1)'(LIFE_STEP);
  localparam logic [2:0]         COMBO_TOP  = 3'(COMBO_MAX);
  localparam logic [3:0]         BONUS_CAP  = 4'(MAX_BONUS);

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [SCORE_W-1:0] award_q, award_d;
  logic [2:0]         combo_q, combo_d;
  logic               life_q, life_d;
  logic               sat_q, sat_d;
  logic [SCORE_W:0]   next_life_q, next_life_d;
  logic [3:0]         bonus_q, bonus_d;

  logic               add_en;
  logic [SCORE_W-1:0] add_val;
  logic [SCORE_W:0]   sum;

  always_comb begin
    score_d     = score_q;
    award_d     = award_q;
    combo_d     = combo_q;
    life_d      = 1'b0;
    sat_d       = sat_q;
    next_life_d = next_life_q;
    bonus_d     = bonus_q;
    add_en      = 1'b0;
    add_val     = '0;
    sum         = '0;

    if (clear) begin
      score_d     = '0;
      award_d     = '0;
      combo_d     = '0;
      sat_d       = 1'b0;
      next_life_d = LIFE_INC;
      bonus_d     = '0;
    end else if (!freeze) begin
      // Life check looks at the registered score, so a crossing pulses one cycle later
      if ({1'b0, score_q} >= next_life_q && bonus_q < BONUS_CAP) begin
        life_d      = 1'b1;
        next_life_d = next_life_q + LIFE_INC;
        bonus_d     = bonus_q + 4'd1;
      end

      if (event_valid) begin
        case (event_type)
          EV_PELLET: begin
            add_en  = 1'b1;
            add_val = PELLET_AWD;
          end
          EV_POWER: begin
            add_en  = 1'b1;
            add_val = POWER_AWD;
            combo_d = '0;
          end
          EV_GHOST: begin
            add_en  = 1'b1;
            add_val = GHOST_AWD << combo_q;
            combo_d = (combo_q >= COMBO_TOP) ? COMBO_TOP : combo_q + 3'd1;
          end
          EV_FRUIT: begin
            add_en  = 1'b1;
            add_val = SCORE_W'(fruit_pts);
          end
          EV_DOUBLE: begin
            award_d = score_q;
            score_d = score_q[SCORE_W-1] ? SCORE_MAX : (score_q << 1);
            sat_d   = sat_q | score_q[SCORE_W-1];
          end
          EV_POWER_END: begin
            combo_d = '0;
            award_d = '0;
          end
          default: ;
        endcase

        if (add_en) begin
          sum     = {1'b0, score_q} + {1'b0, add_val};
          award_d = add_val;
          if (sum[SCORE_W]) begin
            score_d = SCORE_MAX;
            sat_d   = 1'b1;
          end else begin
            score_d = sum[SCORE_W-1:0];
          end
        end
      end
    end

    high_d = (score_d > high_q) ? score_d : high_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q     <= '0;
      high_q      <= '0;
      award_q     <= '0;
      combo_q     <= '0;
      life_q      <= 1'b0;
      sat_q       <= 1'b0;
      next_life_q <= LIFE_INC;
      bonus_q     <= '0;
    end else begin
      score_q     <= score_d;
      high_q      <= high_d;
      award_q     <= award_d;
      combo_q     <= combo_d;
      life_q      <= life_d;
      sat_q       <= sat_d;
      next_life_q <= next_life_d;
      bonus_q     <= bonus_d;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign last_award = award_q;
  assign combo      = combo_q;
  assign extra_life = life_q;
  assign saturated  = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_score_engine.sv
// +----------------------------------------------------------------------------+
// | tb_score_engine: scoreboard bench with an arithmetic model of the engine   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_score_engine;

  localparam int     W      = 16;
  localparam int     MAXB   = 2;
  localparam longint LIFE   = 10000;
  localparam longint MAXV   = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         freeze = 1'b0;
  logic         event_valid = 1'b0;
  logic [2:0]   event_type = 3'd0;
  logic [15:0]  fruit_pts = 16'd0;
  logic [W-1:0] score, high_score, last_award;
  logic [2:0]   combo;
  logic         extra_life, saturated;

  score_engine #(.SCORE_W(W), .MAX_BONUS(MAXB)) dut (
    .clk(clk), .reset(reset), .clear(clear), .freeze(freeze),
    .event_valid(event_valid), .event_type(event_type), .fruit_pts(fruit_pts),
    .score(score), .high_score(high_score), .last_award(last_award),
    .combo(combo), .extra_life(extra_life), .saturated(saturated)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint score, high, award, combo, life, sat;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference state, kept as plain integers
  longint m_score, m_high, m_award, m_combo, m_sat, m_next, m_bonus, m_life;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset(input bit keep_high);
    m_score = 0; m_award = 0; m_combo = 0; m_sat = 0;
    m_next = LIFE; m_bonus = 0; m_life = 0;
    if (!keep_high) m_high = 0;
  endtask

  task automatic model_add(input longint a);
    m_award = a;
    if (m_score + a > MAXV) begin m_score = MAXV; m_sat = 1; end
    else m_score = m_score + a;
  endtask

  task automatic model_step(input bit v, input int t, input longint f, input bit frz, input bit clr);
    if (clr) begin
      model_reset(1'b1);
    end else if (frz) begin
      m_life = 0;
    end else begin
      m_life = (m_score >= m_next && m_bonus < MAXB) ? 1 : 0;
      if (m_life == 1) begin m_next += LIFE; m_bonus++; end
      if (v) begin
        case (t)
          0: model_add(10);
          1: begin model_add(50); m_combo = 0; end
          2: begin model_add(200 * (64'd1 << m_combo)); m_combo = (m_combo < 3) ? m_combo + 1 : 3; end
          3: model_add(f);
          4: begin
            m_award = m_score;
            if (m_score * 2 > MAXV) begin m_score = MAXV; m_sat = 1; end
            else m_score = m_score * 2;
          end
          5: begin m_combo = 0; m_award = 0; end
          default: ;
        endcase
      end
    end
    if (m_score > m_high) m_high = m_score;
  endtask

  task automatic step(input bit v, input int t, input int f, input bit frz, input bit clr);
    exp_t e;
    @(negedge clk);
    event_valid = v; event_type = t[2:0]; fruit_pts = f[15:0];
    freeze = frz; clear = clr;
    model_step(v, t, longint'(f[15:0]), frz, clr);
    e.score = m_score; e.high = m_high; e.award = m_award;
    e.combo = m_combo; e.life = m_life; e.sat = m_sat;
    q.push_back(e);
  endtask

  task automatic ev(input int t, input int f);
    step(1'b1, t, f, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_score"}, longint'(score), 0);
    chk({tag, "_high"}, longint'(high_score), 0);
    chk({tag, "_award"}, longint'(last_award), 0);
    chk({tag, "_combo"}, longint'(combo), 0);
    chk({tag, "_life"}, longint'(extra_life), 0);
    chk({tag, "_sat"}, longint'(saturated), 0);
  endtask

  // Monitor: every edge the DUT presents a new state; compare against the oldest prediction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_score", longint'(score), e.score);
      chk("sb_high", longint'(high_score), e.high);
      chk("sb_award", longint'(last_award), e.award);
      chk("sb_combo", longint'(combo), e.combo);
      chk("sb_life", longint'(extra_life), e.life);
      chk("sb_sat", longint'(saturated), e.sat);
      chk("sb_high_ge_score", (high_score >= score) ? 1 : 0, 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset(1'b0);
    #3;
    check_all_zero("por");
    @(negedge clk);
    reset = 1'b0;

    // Pellets and power pellet
    ev(0, 0); settle(); chk("t1_s10", longint'(score), 10);
    ev(0, 0); settle(); chk("t1_s20", longint'(score), 20);
    ev(0, 0); settle(); chk("t1_s30", longint'(score), 30);
    ev(1, 0); settle(); chk("t1_s80", longint'(score), 80);
    chk("t1_award", longint'(last_award), 50);

    // Ghost combo
    step(1'b0, 0, 0, 1'b0, 1'b1);
    ev(1, 0);
    for (int i = 0; i < 5; i++) ev(2, 0);
    settle();
    chk("t2_score", longint'(score), 4650);
    chk("t2_combo", longint'(combo), 3);
    chk("t2_award", longint'(last_award), 1600);
    ev(5, 0); settle();
    chk("t2_pe_combo", longint'(combo), 0);
    chk("t2_pe_score", longint'(score), 4650);

    // Multiple thresholds in one event, capped at two lives
    step(1'b0, 0, 0, 1'b0, 1'b1);
    ev(3, 9990);
    ev(3, 30000); settle();
    chk("t3_score", longint'(score), 39990);
    chk("t3_life_edge0", longint'(extra_life), 0);
    idle(); settle(); chk("t3_life1", longint'(extra_life), 1);
    idle(); settle(); chk("t3_life2", longint'(extra_life), 1);
    idle(); settle(); chk("t3_life_cap", longint'(extra_life), 0);

    // Saturation on add and on double
    step(1'b0, 0, 0, 1'b0, 1'b1);
    ev(3, 65530);
    ev(0, 0); settle();
    chk("t4_sat_score", longint'(score), 65535);
    chk("t4_sat_flag", longint'(saturated), 1);
    chk("t4_sat_award", longint'(last_award), 10);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    ev(3, 200); ev(4, 0); settle();
    chk("t4_dbl_400", longint'(score), 400);
    chk("t4_dbl_nosat", longint'(saturated), 0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    ev(3, 40000); ev(4, 0); settle();
    chk("t4_dbl_clip", longint'(score), 65535);
    chk("t4_dbl_award", longint'(last_award), 40000);

    // Asynchronous reset between edges
    @(posedge clk); #3;
    reset = 1'b1; event_valid = 1'b0; clear = 1'b0; freeze = 1'b0;
    #1;
    check_all_zero("arst");
    model_reset(1'b0);
    @(negedge clk);
    reset = 1'b0;

    // High score survives clear; clear drops a coincident event
    ev(3, 500);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    ev(3, 120); settle();
    chk("t5_score", longint'(score), 120);
    chk("t5_high", longint'(high_score), 500);
    step(1'b1, 3, 777, 1'b0, 1'b1); settle();
    chk("t5_clr_drop", longint'(score), 0);
    chk("t5_clr_high", longint'(high_score), 500);

    // Freeze holds state and defers a pending life
    ev(3, 9000);
    for (int i = 0; i < 4; i++) step(1'b1, 0, 0, 1'b1, 1'b0);
    settle(); chk("t6_frz_score", longint'(score), 9000);
    ev(3, 1000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 0, 1'b1, 1'b0); settle();
      chk("t6_frz_nolife", longint'(extra_life), 0);
    end
    idle(); settle(); chk("t6_resume_life", longint'(extra_life), 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit v, frz, clr;
      int t, f;
      v   = ($urandom_range(0, 9) < 7);
      frz = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 59) == 0);
      t   = int'($urandom_range(0, 7));
      f   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 3000));
      step(v, t, f, frz, clr);
    end

    begin
      int budget;
      budget = 10;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk); #2;
        budget--;
      end
      chk("drain_queue", longint'(q.size()), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
